// File: rtl/eth_phy_10g_rx_ber_mon.sv
// ---------------------------------------------------------------------------
// eth_phy_10g_rx_ber_mon
//
// 10GBASE-R receive bit-error-rate monitor. Watches the 2-bit sync header of
// every received block. It raises high BER when BER_THRESHOLD or more invalid
// headers arrive within one 125 us window. It also keeps a saturating
// cumulative invalid-header count for management readout.
//
// Ports:
//   clk               block clock, all logic on the rising edge
//   rst               synchronous, active-high reset
//   serdes_rx_hdr     sync header of the current block (one block per cycle)
//   rx_block_lock     block lock from the frame-sync stage
//   rx_ber_count_clr  one-cycle pulse, clears rx_ber_count
//   rx_high_ber       registered high-BER status
//   rx_ber_count      cumulative invalid-header count, saturates at 63
//   rx_window_done    one-cycle pulse, high the cycle after a window ends
// ---------------------------------------------------------------------------
module eth_phy_10g_rx_ber_mon #(
  parameter int HDR_WIDTH     = 2,
  parameter int COUNT_125US   = 19531,
  parameter int BER_THRESHOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
  input  logic                 rx_block_lock,
  input  logic                 rx_ber_count_clr,
  output logic                 rx_high_ber,
  output logic [5:0]           rx_ber_count,
  output logic                 rx_window_done
);

  // Reject unsupported parameterisations at elaboration time.
  if (HDR_WIDTH != 2) begin : g_bad_hdr_width
    $error("eth_phy_10g_rx_ber_mon: HDR_WIDTH must be 2");
  end
  if (COUNT_125US < 2) begin : g_bad_count
    $error("eth_phy_10g_rx_ber_mon: COUNT_125US must be >= 2");
  end
  if ((BER_THRESHOLD < 1) || (BER_THRESHOLD > 31)) begin : g_bad_threshold
    $error("eth_phy_10g_rx_ber_mon: BER_THRESHOLD must be in 1..31");
  end

  localparam int TW = $clog2(COUNT_125US);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(COUNT_125US - 1);
  localparam logic [5:0]    THRESH     = 6'(BER_THRESHOLD);

  logic [TW-1:0] r_timer;
  logic [4:0]    r_win_cnt;
  logic          r_high_ber;
  logic [5:0]    r_ber_count;
  logic          r_window_done;

  logic          w_hdr_valid;
  logic          w_err;
  logic          w_terminal;
  logic [5:0]    w_win_sum;

  // Decode the header and derive per-cycle window events.
  always_comb begin
    w_hdr_valid = (serdes_rx_hdr == 2'b01) || (serdes_rx_hdr == 2'b10);
    w_err       = rx_block_lock && !w_hdr_valid;
    w_terminal  = rx_block_lock && (r_timer == '0);
    // Window total including the current sample, so a threshold-reaching
    // error (even on the terminal cycle) is seen in the same cycle.
    w_win_sum   = {1'b0, r_win_cnt} + {5'b00000, w_err};
  end

  // Window timer: held at the reload value while unlocked so the first
  // locked cycle always starts a fresh window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= TIMER_LOAD;
    end else if (!rx_block_lock || w_terminal) begin
      r_timer <= TIMER_LOAD;
    end else begin
      r_timer <= r_timer - TW'(1);
    end
  end

  // Per-window invalid-header count, saturating at 31.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_cnt <= 5'd0;
    end else if (!rx_block_lock || w_terminal) begin
      r_win_cnt <= 5'd0;
    end else if (w_err && (r_win_cnt != 5'd31)) begin
      r_win_cnt <= r_win_cnt + 5'd1;
    end else begin
      r_win_cnt <= r_win_cnt;
    end
  end

  // High-BER flag: sets as soon as the window total reaches the threshold,
  // clears only at a window boundary whose total stayed below it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_high_ber <= 1'b0;
    end else if (!rx_block_lock) begin
      r_high_ber <= 1'b0;
    end else if (w_win_sum >= THRESH) begin
      r_high_ber <= 1'b1;
    end else if (w_terminal) begin
      r_high_ber <= 1'b0;
    end else begin
      r_high_ber <= r_high_ber;
    end
  end

  // Window-done pulse, one cycle after the terminal cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_window_done <= 1'b0;
    end else begin
      r_window_done <= w_terminal;
    end
  end

  // Cumulative count; an error coinciding with a clear lands after the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ber_count <= 6'd0;
    end else if (rx_ber_count_clr) begin
      r_ber_count <= w_err ? 6'd1 : 6'd0;
    end else if (w_err && (r_ber_count != 6'd63)) begin
      r_ber_count <= r_ber_count + 6'd1;
    end else begin
      r_ber_count <= r_ber_count;
    end
  end

  assign rx_high_ber    = r_high_ber;
  assign rx_ber_count   = r_ber_count;
  assign rx_window_done = r_window_done;

endmodule

// File: tb/tb_eth_phy_10g_rx_ber_mon.sv
// ---------------------------------------------------------------------------
// tb_eth_phy_10g_rx_ber_mon
//
// Directed bench for eth_phy_10g_rx_ber_mon with a 100-cycle window.
// Inputs are set 1 time unit after a rising edge. Outputs are sampled 1 time
// unit after the following edge. Each check therefore sees the registered
// result of the cycle just driven. Window cycle numbers (w) in the comments
// count from 0 at the first locked cycle of each window.
// ---------------------------------------------------------------------------
module tb_eth_phy_10g_rx_ber_mon;

  localparam int CNT = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] hdr;
  logic       lock;
  logic       clr;
  logic       high_ber;
  logic [5:0] ber_count;
  logic       window_done;

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;

  always #5 clk = ~clk;

  eth_phy_10g_rx_ber_mon #(
    .HDR_WIDTH     (2),
    .COUNT_125US   (CNT),
    .BER_THRESHOLD (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .serdes_rx_hdr    (hdr),
    .rx_block_lock    (lock),
    .rx_ber_count_clr (clr),
    .rx_high_ber      (high_ber),
    .rx_ber_count     (ber_count),
    .rx_window_done   (window_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic [1:0] h);
    hdr = h;
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst  = 1'b1;
    lock = 1'b1;
    clr  = 1'b0;
    hdr  = 2'b10;
    tick();
    tick();
    chk("rst_high_ber", {7'd0, high_ber}, 8'd0);
    chk("rst_ber_count", {2'd0, ber_count}, 8'd0);
    chk("rst_window_done", {7'd0, window_done}, 8'd0);
    rst = 1'b0;

    // 300 clean cycles: pulses after window cycles 99, 199, 299.
    for (int c = 0; c < 300; c++) begin
      tick();
      if (window_done) done_seen++;
      if ((c % CNT) == (CNT - 1)) chk("t1_done_pulse", {7'd0, window_done}, 8'd1);
      else if ((c % CNT) == (CNT - 2)) chk("t1_done_quiet", {7'd0, window_done}, 8'd0);
    end
    chk("t1_done_total", 8'(done_seen), 8'd3);
    chk("t1_high_ber", {7'd0, high_ber}, 8'd0);
    chk("t1_ber_count", {2'd0, ber_count}, 8'd0);

    // Window A: 16 errors at w=10..25.
    run(10, 2'b10);
    run(15, 2'b11);
    chk("t2_after_15_errs", {7'd0, high_ber}, 8'd0);
    run(1, 2'b11);
    chk("t2_after_16_errs", {7'd0, high_ber}, 8'd1);
    run(73, 2'b10);                               // w=26..98
    chk("t2_hold_in_window", {7'd0, high_ber}, 8'd1);
    chk("t2_done_quiet", {7'd0, window_done}, 8'd0);
    run(1, 2'b10);                                // w=99 terminal
    chk("t2_hold_at_boundary", {7'd0, high_ber}, 8'd1);
    chk("t2_done_pulse", {7'd0, window_done}, 8'd1);
    chk("t2_ber_count", {2'd0, ber_count}, 8'd16);
    // Window B: clean; clears after its terminal cycle.
    run(99, 2'b10);
    chk("t2_hold_clean_window", {7'd0, high_ber}, 8'd1);
    run(1, 2'b10);
    chk("t2_clear_at_boundary", {7'd0, high_ber}, 8'd0);
    chk("t2_done_pulse_b", {7'd0, window_done}, 8'd1);

    // Window C: 15 errors at w=0..14, 16th on the terminal cycle.
    run(15, 2'b11);
    run(84, 2'b10);                               // w=15..98
    chk("t3_below_thresh", {7'd0, high_ber}, 8'd0);
    run(1, 2'b11);                                // w=99 error
    chk("t3_set_on_terminal", {7'd0, high_ber}, 8'd1);
    chk("t3_done_pulse", {7'd0, window_done}, 8'd1);
    // Window D: 15 errors; clears only if the window count restarted.
    run(15, 2'b11);
    chk("t3_hold_next_window", {7'd0, high_ber}, 8'd1);
    run(85, 2'b10);                               // w=15..99
    chk("t3_clear_win_restart", {7'd0, high_ber}, 8'd0);
    chk("t3_done_pulse_d", {7'd0, window_done}, 8'd1);
    chk("t3_ber_count", {2'd0, ber_count}, 8'd47);

    // Window E: 29 more errors (47+29=76) saturate at 63.
    run(29, 2'b11);                               // w=0..28
    chk("t4_saturate", {2'd0, ber_count}, 8'd63);
    chk("t4_high_ber", {7'd0, high_ber}, 8'd1);
    clr = 1'b1;
    run(1, 2'b11);                                // w=29 clear + error
    chk("t4_clr_with_err", {2'd0, ber_count}, 8'd1);
    run(1, 2'b10);                                // w=30 clear alone
    clr = 1'b0;
    chk("t4_clr_alone", {2'd0, ber_count}, 8'd0);
    run(10, 2'b10);                               // w=31..40

    // Lock drop for 5 cycles while high BER is set.
    lock = 1'b0;
    run(1, 2'b11);
    chk("t5_unlock_high_ber", {7'd0, high_ber}, 8'd0);
    chk("t5_unlock_done", {7'd0, window_done}, 8'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_unlock_done_quiet", {7'd0, window_done}, 8'd0);
    end
    chk("t5_unlock_no_count", {2'd0, ber_count}, 8'd0);
    lock = 1'b1;
    // Window F: fresh after relock, 8 errors.
    run(8, 2'b11);
    run(91, 2'b10);                               // w=8..98
    chk("t5_relock_done_quiet", {7'd0, window_done}, 8'd0);
    run(1, 2'b10);                                // w=99
    chk("t5_relock_done_pulse", {7'd0, window_done}, 8'd1);
    chk("t5_relock_high_ber", {7'd0, high_ber}, 8'd0);

    // Window G: 12 errors (window=12, total=20), then reset.
    run(12, 2'b11);
    chk("t6_pre_rst_count", {2'd0, ber_count}, 8'd20);
    chk("t6_pre_rst_high_ber", {7'd0, high_ber}, 8'd0);
    rst = 1'b1;
    run(1, 2'b10);
    chk("t6_rst_high_ber", {7'd0, high_ber}, 8'd0);
    chk("t6_rst_ber_count", {2'd0, ber_count}, 8'd0);
    chk("t6_rst_done", {7'd0, window_done}, 8'd0);
    rst = 1'b0;
    run(4, 2'b11);
    chk("t6_post_rst_high_ber", {7'd0, high_ber}, 8'd0);
    chk("t6_post_rst_count", {2'd0, ber_count}, 8'd4);
    run(95, 2'b10);                               // w=4..98
    chk("t6_post_rst_done_quiet", {7'd0, window_done}, 8'd0);
    run(1, 2'b10);                                // w=99
    chk("t6_post_rst_done_pulse", {7'd0, window_done}, 8'd1);
    chk("t6_post_rst_final_ber", {7'd0, high_ber}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
